// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- hazard detection and forwarding control for a 5-stage
// in-order pipeline (IF, ID, EX, MEM, WB).
//
// Purpose
//   Keeps small shadow records of the instructions now in EX and MEM
//   (destination register, writeback enable, load flag). From these it
//   derives the operand forwarding selects for the instruction in ID,
//   detects load-use hazards, and sequences stalls, flushes and memory-wait
//   freezes.
//
// Per-cycle priority: mem_busy (freeze) > ex_branch_taken (flush) > load-use.
//
// Optional feature
//   HAZARD_PERF_CNT_EN : when defined, adds output stall_cycles, a
//   saturating count of the cycles in which pc_stall was 1.
//
// Ports
//   clk                    in   pipeline clock, rising edge
//   rst                    in   asynchronous reset, active low
//   id_valid               in   valid instruction in ID
//   id_rs1_addr/rs2_addr   in   ID source registers (5 bits each)
//   id_uses_rs1/rs2        in   source actually read by the ID instruction
//   id_rd_addr             in   ID destination register
//   id_writeback_en        in   ID instruction writes rd
//   id_writeback_from_mem  in   ID instruction is a load
//   ex_branch_taken        in   taken branch/jump resolved in EX
//   mem_busy               in   data memory not ready this cycle
//   pc_stall, if_id_stall  out  hold PC and IF/ID
//   if_id_flush            out  IF/ID becomes a NOP
//   id_ex_bubble           out  ID/EX loads a NOP
//   pipe_freeze            out  hold ID/EX, EX/MEM and MEM/WB
//   rs1/rs2_take_prev1     out  forward from the EX-stage result
//   rs1/rs2_take_prev2     out  forward from the MEM/WB result
//   dbg_state              out  current FSM state (0 RUN, 1 LOAD_STALL,
//                               2 MEM_WAIT)
//   stall_cycles           out  (HAZARD_PERF_CNT_EN only) stall cycle count
//
// Handshake note: there is no valid/ready pair here. id_valid qualifies the
// ID fields for the cycle it is high; mem_busy acts as a not-ready for the
// whole back end and takes effect combinationally in the same cycle.
// ---------------------------------------------------------------------------
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd_addr,
  input  logic       id_writeback_en,
  input  logic       id_writeback_from_mem,
  input  logic       ex_branch_taken,
  input  logic       mem_busy,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       pipe_freeze,
  output logic       rs1_take_prev1,
  output logic       rs2_take_prev1,
  output logic       rs1_take_prev2,
  output logic       rs2_take_prev2,
  output logic [1:0] dbg_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  state_t     r_state;

  // Shadow stage records.
  logic [4:0] r_ex_rd;
  logic       r_ex_wb;
  logic       r_ex_load;
  logic [4:0] r_mem_rd;
  logic       r_mem_wb;
  logic       r_mem_load;

  logic w_ex_live;
  logic w_mem_live;
  logic w_rs1_ex;
  logic w_rs2_ex;
  logic w_rs1_mem;
  logic w_rs2_mem;
  logic w_load_use;
  logic w_freeze;
  logic w_flush;
  logic w_lu_stall;
  logic w_bubble;
  logic w_pc_stall;
  logic w_fwd_ok;
  logic w_rs1_p1;
  logic w_rs2_p1;
  logic w_rs1_p2;
  logic w_rs2_p2;

  // A record only produces a value if it writes back a register other
  // than x0; this is what keeps x0 from ever being forwarded or stalled on.
  assign w_ex_live  = r_ex_wb  && (r_ex_rd  != 5'd0);
  assign w_mem_live = r_mem_wb && (r_mem_rd != 5'd0);

  assign w_rs1_ex  = id_valid && id_uses_rs1 && w_ex_live  && (id_rs1_addr == r_ex_rd);
  assign w_rs2_ex  = id_valid && id_uses_rs2 && w_ex_live  && (id_rs2_addr == r_ex_rd);
  assign w_rs1_mem = id_valid && id_uses_rs1 && w_mem_live && (id_rs1_addr == r_mem_rd);
  assign w_rs2_mem = id_valid && id_uses_rs2 && w_mem_live && (id_rs2_addr == r_mem_rd);

  assign w_load_use = r_ex_load && (w_rs1_ex || w_rs2_ex);

  // Priority chain: freeze masks everything, a taken branch masks load-use.
  assign w_freeze   = mem_busy;
  assign w_flush    = !w_freeze && ex_branch_taken;
  assign w_lu_stall = !w_freeze && !ex_branch_taken && w_load_use;
  assign w_bubble   = w_flush || w_lu_stall;
  assign w_pc_stall = w_freeze || w_lu_stall;

  // Forwarding is meaningless when the ID instruction will not advance.
  assign w_fwd_ok = !w_freeze && !w_bubble;
  assign w_rs1_p1 = w_fwd_ok && w_rs1_ex && !r_ex_load;
  assign w_rs2_p1 = w_fwd_ok && w_rs2_ex && !r_ex_load;
  assign w_rs1_p2 = w_fwd_ok && w_rs1_mem && !w_rs1_p1;
  assign w_rs2_p2 = w_fwd_ok && w_rs2_mem && !w_rs2_p1;

  // Outputs must drop as soon as rst falls, not at the next edge, so the
  // combinational results are qualified by rst directly.
  assign pc_stall       = rst && w_pc_stall;
  assign if_id_stall    = rst && w_pc_stall;
  assign if_id_flush    = rst && w_flush;
  assign id_ex_bubble   = rst && w_bubble;
  assign pipe_freeze    = rst && w_freeze;
  assign rs1_take_prev1 = rst && w_rs1_p1;
  assign rs2_take_prev1 = rst && w_rs2_p1;
  assign rs1_take_prev2 = rst && w_rs1_p2;
  assign rs2_take_prev2 = rst && w_rs2_p2;
  assign dbg_state      = r_state;

  // The output equations are identical in every state: after a load-use
  // bubble EX holds a NOP, so the re-evaluated instruction naturally sees
  // the load in MEM (prev2); after a freeze the held records reproduce the
  // pre-freeze evaluation. The state register tracks which phase we are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_ex_rd    <= 5'd0;
      r_ex_wb    <= 1'b0;
      r_ex_load  <= 1'b0;
      r_mem_rd   <= 5'd0;
      r_mem_wb   <= 1'b0;
      r_mem_load <= 1'b0;
    end else begin
      if (w_freeze) begin
        r_state <= ST_MEM_WAIT;
      end else if (w_lu_stall) begin
        r_state <= ST_LOAD_STALL;
      end else begin
        r_state <= ST_RUN;
      end

      if (!w_freeze) begin
        r_mem_rd   <= r_ex_rd;
        r_mem_wb   <= r_ex_wb;
        r_mem_load <= r_ex_load;
        if (id_valid && !w_bubble) begin
          r_ex_rd   <= id_rd_addr;
          r_ex_wb   <= id_writeback_en;
          r_ex_load <= id_writeback_from_mem;
        end else begin
          r_ex_rd   <= 5'd0;
          r_ex_wb   <= 1'b0;
          r_ex_load <= 1'b0;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_pc_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
// Output vector bit order used by the expected values:
//   [8] pc_stall [7] if_id_stall [6] if_id_flush [5] id_ex_bubble
//   [4] pipe_freeze [3] rs1_take_prev1 [2] rs2_take_prev1
//   [1] rs1_take_prev2 [0] rs2_take_prev2
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [8:0] E_NONE = 9'h000;
  localparam logic [8:0] E_LU   = 9'h1A0;
  localparam logic [8:0] E_BR   = 9'h060;
  localparam logic [8:0] E_FRZ  = 9'h190;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_LS   = 2'd1;
  localparam logic [1:0] S_MW   = 2'd2;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_rd_addr;
  logic       id_writeback_en;
  logic       id_writeback_from_mem;
  logic       ex_branch_taken;
  logic       mem_busy;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       pipe_freeze;
  logic       rs1_take_prev1;
  logic       rs2_take_prev1;
  logic       rs1_take_prev2;
  logic       rs2_take_prev2;
  logic [1:0] dbg_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  logic [8:0] exp_q[$];
  int         n_tests;
  int         n_fail;
  int         exp_stalls;

  hazard_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .id_valid              (id_valid),
    .id_rs1_addr           (id_rs1_addr),
    .id_rs2_addr           (id_rs2_addr),
    .id_uses_rs1           (id_uses_rs1),
    .id_uses_rs2           (id_uses_rs2),
    .id_rd_addr            (id_rd_addr),
    .id_writeback_en       (id_writeback_en),
    .id_writeback_from_mem (id_writeback_from_mem),
    .ex_branch_taken       (ex_branch_taken),
    .mem_busy              (mem_busy),
    .pc_stall              (pc_stall),
    .if_id_stall           (if_id_stall),
    .if_id_flush           (if_id_flush),
    .id_ex_bubble          (id_ex_bubble),
    .pipe_freeze           (pipe_freeze),
    .rs1_take_prev1        (rs1_take_prev1),
    .rs2_take_prev1        (rs2_take_prev1),
    .rs1_take_prev2        (rs1_take_prev2),
    .rs2_take_prev2        (rs2_take_prev2),
    .dbg_state             (dbg_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles          (stall_cycles)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wb, input logic ld);
    id_valid              = v;
    id_rs1_addr           = rs1;
    id_rs2_addr           = rs2;
    id_uses_rs1           = u1;
    id_uses_rs2           = u2;
    id_rd_addr            = rd;
    id_writeback_en       = wb;
    id_writeback_from_mem = ld;
  endtask

  task automatic set_ctl(input logic br, input logic busy);
    ex_branch_taken = br;
    mem_busy        = busy;
  endtask

  // Scoreboard: expectation queued with the stimulus, popped when sampled.
  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    logic [8:0] e;
    exp_q.push_back(exp);
    #2;
    got = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze,
           rs1_take_prev1, rs2_take_prev1, rs1_take_prev2, rs2_take_prev2};
    e = exp_q.pop_front();
    n_tests++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: outputs got=%h exp=%h", tag, got, e);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    n_tests++;
    assert (dbg_state === exp) else begin
      n_fail++;
      $error("FAIL %s: state got=%0d exp=%0d", tag, dbg_state, exp);
    end
  endtask

  // Check outputs for the current cycle, then advance past the next edge.
  task automatic step(input string tag, input logic [8:0] exp);
    check(tag, exp);
    if (rst && exp[8]) exp_stalls++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp_stalls = 0;
    rst        = 1'b0;
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    set_ctl(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    // Hazard-looking inputs must not leak through while reset is held.
    check("reset_outputs", E_NONE);
    check_state("reset_state", S_RUN);
`ifdef HAZARD_PERF_CNT_EN
    n_tests++;
    assert (stall_cycles === 32'd0) else begin
      n_fail++;
      $error("FAIL reset_cnt: got=%0d exp=0", stall_cycles);
    end
`endif
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_ctl(1'b0, 1'b0);
    rst = 1'b1;
    #1;

    // Load-use: lw x5 ; add x6,x5,x1
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step("lw_x5_issue", E_NONE);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    step("load_use_stall", E_LU);
    check_state("state_load_stall", S_LS);
    step("load_use_prev2", 9'h002);
    check_state("state_back_run", S_RUN);

    // ALU forwarding: add x5 ; sub x7,x5,x5 ; then x7 (prev1) and x5 (prev2)
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step("add_x5_issue", E_NONE);
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    step("sub_both_prev1", 9'h00C);
    set_id(1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
    step("prev1_and_prev2", 9'h009);
    set_id(1'b0, 5'd7, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step("invalid_no_fwd", E_NONE);

    // Load-use coincident with a taken branch: branch wins.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    step("lw_x5_again", E_NONE);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    set_ctl(1'b1, 1'b0);
    step("branch_over_load_use", E_BR);
    check_state("state_run_after_branch", S_RUN);
    set_ctl(1'b0, 1'b0);
    step("after_branch_prev2", 9'h002);

    // mem_busy for 3 cycles during a load-use.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
    step("lw_x8_issue", E_NONE);
    set_id(1'b1, 5'd8, 5'd6, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    set_ctl(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("freeze_%0d", i), E_FRZ);
      check_state($sformatf("state_mem_wait_%0d", i), S_MW);
    end
    set_ctl(1'b0, 1'b0);
    step("load_use_after_freeze", E_LU);
    check_state("state_ls_after_freeze", S_LS);
    step("prev2_after_freeze", 9'h002);

    // x0 destinations never forward or stall.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("load_to_x0", E_NONE);
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step("read_x0_ex", E_NONE);
    step("read_x0_mem", E_NONE);

    // id_uses gating on a matching address.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
    step("add_x10_issue", E_NONE);
    set_id(1'b1, 5'd10, 5'd10, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step("uses_gating", 9'h004);

    // Reset pulsed during LOAD_STALL.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b1);
    step("lw_x11_issue", E_NONE);
    set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);
    step("load_use_x11", E_LU);
    check_state("state_ls_before_rst", S_LS);
    set_ctl(1'b1, 1'b1);
    rst = 1'b0;
    exp_stalls = 0;
    check("async_rst_outputs", E_NONE);
    check_state("async_rst_state", S_RUN);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_ctl(1'b0, 1'b0);
    step("after_rst_no_hazard", E_NONE);
    check_state("after_rst_state", S_RUN);

`ifdef HAZARD_PERF_CNT_EN
    // One more stall after reset so the counter is non-zero.
    set_ctl(1'b0, 1'b1);
    step("cnt_freeze", E_FRZ);
    set_ctl(1'b0, 1'b0);
    n_tests++;
    assert (stall_cycles === exp_stalls) else begin
      n_fail++;
      $error("FAIL stall_cycles: got=%0d exp=%0d", stall_cycles, exp_stalls);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
